// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: assembles little-endian words from a
// byte stream, writes them at consecutive indices, then releases the CPU.
module imem_loader #(
   parameter int unsigned DEPTH = 64,
   parameter int unsigned LEN_W = 7,
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_start,
   input  logic [LEN_W-1:0] load_len,
   input  logic [7:0]       rx_data,
   input  logic             rx_valid,
   output logic             rx_ready,
   output logic [63:0]      ins_addr,
   output logic [WIDTH-1:0] instruction,
   output logic             W_R,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [WIDTH-1:0] checksum,
   output logic             cpu_run
);

   typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;

   state_t           state, state_d;
   logic [1:0]       byte_cnt, byte_cnt_d;
   logic [LEN_W-1:0] word_cnt, word_cnt_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic [63:0]      ins_addr_d;
   logic [WIDTH-1:0] instruction_d, checksum_d;
   logic             err_d, start_ok;
   logic             rx_ready_d, w_r_d, busy_d, done_d, cpu_run_d;

   // Registers; output flags are precomputed from the next state so they
   // line up with the state they describe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         byte_cnt    <= '0;
         word_cnt    <= '0;
         len_q       <= '0;
         ins_addr    <= '0;
         instruction <= '0;
         checksum    <= '0;
         err         <= 1'b0;
         rx_ready    <= 1'b0;
         W_R         <= 1'b1;
         busy        <= 1'b0;
         done        <= 1'b0;
         cpu_run     <= 1'b0;
      end else begin
         state       <= state_d;
         byte_cnt    <= byte_cnt_d;
         word_cnt    <= word_cnt_d;
         len_q       <= len_d;
         ins_addr    <= ins_addr_d;
         instruction <= instruction_d;
         checksum    <= checksum_d;
         err         <= err_d;
         rx_ready    <= rx_ready_d;
         W_R         <= w_r_d;
         busy        <= busy_d;
         done        <= done_d;
         cpu_run     <= cpu_run_d;
      end
   end

   // Next-state and datapath updates.
   always_comb begin
      state_d       = state;
      byte_cnt_d    = byte_cnt;
      word_cnt_d    = word_cnt;
      len_d         = len_q;
      ins_addr_d    = ins_addr;
      instruction_d = instruction;
      checksum_d    = checksum;
      err_d         = err;
      start_ok      = (load_len != '0) && (load_len <= LEN_W'(DEPTH));

      case (state)
         IDLE, DONE: begin
            if (load_start) begin
               if (start_ok) begin
                  len_d      = load_len;
                  checksum_d = '0;
                  word_cnt_d = '0;
                  ins_addr_d = '0;
                  byte_cnt_d = '0;
                  err_d      = 1'b0;
                  state_d    = LOAD;
               end else begin
                  err_d   = 1'b1;
                  state_d = DONE;
               end
            end
         end
         LOAD: begin
            if (rx_valid && rx_ready) begin
               instruction_d[{byte_cnt, 3'b000} +: 8] = rx_data;
               byte_cnt_d = byte_cnt + 2'd1;
               if (byte_cnt == 2'd3) state_d = WRITE;
            end
         end
         WRITE: begin
            checksum_d = checksum ^ instruction;
            word_cnt_d = word_cnt + LEN_W'(1);
            if (word_cnt_d == len_q) begin
               state_d = DONE;
            end else begin
               ins_addr_d = ins_addr + 64'd1;
               byte_cnt_d = '0;
               state_d    = LOAD;
            end
         end
         default: state_d = IDLE;
      endcase

      rx_ready_d = (state_d == LOAD);
      busy_d     = (state_d == LOAD) || (state_d == WRITE);
      w_r_d      = !busy_d;
      done_d     = (state_d == DONE);
      cpu_run_d  = (state_d == DONE) && !err_d;
   end

endmodule
